// File: rtl/memory_responder_latency.sv
// Read responder for the valid/ready/next-cycle-data protocol: serves single-word
// reads from on-chip RAM after a fixed, parameterized number of cycles.
module memory_responder_latency #(
  parameter int DWIDTH         = 16,
  parameter int ADDR_WIDTH     = 16,
  parameter int MEM_DEPTH_BITS = 10,
  parameter int LATENCY        = 2,
  parameter int COUNT_WIDTH    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  output logic                   req_ready,
  output logic [DWIDTH-1:0]      rsp_data,
  input  logic                   wr_en,
  input  logic [ADDR_WIDTH-1:0]  wr_addr,
  input  logic [DWIDTH-1:0]      wr_data,
  output logic                   busy,
  output logic [COUNT_WIDTH-1:0] req_count
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCEPT, S_DATA} state_t;

  // S_WAIT spends WAIT_INIT+1 cycles, S_IDLE and S_ACCEPT one each.
  localparam logic [7:0] WAIT_INIT = (LATENCY >= 2) ? 8'(LATENCY - 2) : 8'd0;

  state_t                   state_q, state_d;
  logic [7:0]               cnt_q, cnt_d;
  logic [DWIDTH-1:0]        rsp_data_q, rsp_data_d;
  logic [COUNT_WIDTH-1:0]   req_count_q, req_count_d;
  logic                     ready;

  logic [DWIDTH-1:0]        mem [2**MEM_DEPTH_BITS];
  logic [MEM_DEPTH_BITS-1:0] rd_idx, wr_idx;

  assign rd_idx = req_addr[MEM_DEPTH_BITS-1:0];
  assign wr_idx = wr_addr[MEM_DEPTH_BITS-1:0];

  generate
    if (ADDR_WIDTH > MEM_DEPTH_BITS) begin : g_alias
      logic unused_hi;
      assign unused_hi = ^{req_addr[ADDR_WIDTH-1:MEM_DEPTH_BITS],
                           wr_addr[ADDR_WIDTH-1:MEM_DEPTH_BITS]};
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ready   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (req_valid) begin
          if (LATENCY == 0) begin
            ready   = 1'b1;
            state_d = S_DATA;
          end else if (LATENCY == 1) begin
            state_d = S_ACCEPT;
          end else begin
            cnt_d   = WAIT_INIT;
            state_d = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (!req_valid)       state_d = S_IDLE;
        else if (cnt_q == '0) state_d = S_ACCEPT;
        else                  cnt_d   = cnt_q - 8'd1;
      end
      S_ACCEPT: begin
        ready   = req_valid;
        state_d = req_valid ? S_DATA : S_IDLE;
      end
      S_DATA:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output register only loads in the accept cycle, so it holds otherwise.
  always_comb begin
    rsp_data_d  = ready ? mem[rd_idx] : rsp_data_q;
    req_count_d = req_count_q + COUNT_WIDTH'(ready);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      rsp_data_q  <= '0;
      req_count_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rsp_data_q  <= rsp_data_d;
      req_count_q <= req_count_d;
    end
  end

  // Non-blocking write against the same-edge read gives read-first behaviour.
  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_idx] <= wr_data;
  end

  assign req_ready = ready;
  assign rsp_data  = rsp_data_q;
  assign busy      = (state_q != S_IDLE);
  assign req_count = req_count_q;

endmodule

// File: tb/tb_memory_responder_latency.sv
// Scoreboard bench: three responders (latency 2/0/3) on a shared write bus;
// expected accept cycle and data are queued at issue and checked by a monitor.
module tb_memory_responder_latency;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [2:0]  vld = '0;
  logic [15:0] req_addr = '0;
  logic        wr_en = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [15:0] wr_data = '0;
  logic [2:0]  rdy;
  logic [2:0]  bsy;
  logic [15:0] rsp [3];
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b, cnt_c;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rdy_cyc = 0;

  typedef struct {int inst; int cyc; logic [15:0] data;} exp_t;
  exp_t exp_q[$];

  logic        pend_vld = 1'b0;
  int          pend_inst = 0;
  logic [15:0] pend_data = '0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  memory_responder_latency #(.LATENCY(2), .COUNT_WIDTH(4)) u_a (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[0]), .req_addr(req_addr),
    .req_ready(rdy[0]), .rsp_data(rsp[0]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(bsy[0]), .req_count(cnt_a));

  memory_responder_latency #(.LATENCY(0)) u_b (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[1]), .req_addr(req_addr),
    .req_ready(rdy[1]), .rsp_data(rsp[1]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(bsy[1]), .req_count(cnt_b));

  memory_responder_latency #(.LATENCY(3)) u_c (
    .clk(clk), .rst_n(rst_n), .req_valid(vld[2]), .req_addr(req_addr),
    .req_ready(rdy[2]), .rsp_data(rsp[2]), .wr_en(wr_en), .wr_addr(wr_addr),
    .wr_data(wr_data), .busy(bsy[2]), .req_count(cnt_c));

  function automatic int lat(input int inst);
    return (inst == 0) ? 2 : (inst == 1) ? 0 : 3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every req_ready must match the head of the queue (instance and
  // cycle); the data is compared one cycle later.
  always @(negedge clk) begin
    if (pend_vld) begin
      checks++;
      if (rsp[pend_inst] !== pend_data) begin
        errors++;
        $display("FAIL rsp_data inst%0d: got %h expected %h", pend_inst, rsp[pend_inst], pend_data);
      end
      pend_vld = 1'b0;
    end
    for (int i = 0; i < 3; i++) begin
      if (rdy[i] === 1'b1) begin
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected req_ready inst%0d at cycle %0d", i, cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          if (e.inst != i || e.cyc != cyc) begin
            errors++;
            $display("FAIL ready timing: got inst%0d cycle %0d expected inst%0d cycle %0d", i, cyc, e.inst, e.cyc);
          end
          pend_vld  = 1'b1;
          pend_inst = i;
          pend_data = e.data;
          last_rdy_cyc = cyc;
        end
      end
    end
  end

  task automatic wr(input logic [15:0] a, input logic [15:0] d);
    @(posedge clk); #1;
    wr_en = 1'b1; wr_addr = a; wr_data = d;
    @(posedge clk); #1;
    wr_en = 1'b0;
  endtask

  // Optionally writes addr<=wd in the expected accept cycle.
  task automatic rd(input int inst, input logic [15:0] a, input logic [15:0] exp,
                    input bit do_wr = 1'b0, input logic [15:0] wd = '0);
    exp_t e;
    int t0, n;
    @(posedge clk); #1;
    t0 = cyc;
    req_addr = a;
    vld[inst] = 1'b1;
    e.inst = inst; e.cyc = t0 + lat(inst); e.data = exp;
    exp_q.push_back(e);
    n = 0;
    forever begin
      if (do_wr && cyc == t0 + lat(inst)) begin
        wr_en = 1'b1; wr_addr = a; wr_data = wd;
      end
      @(negedge clk);
      if (rdy[inst] === 1'b1) break;
      n++;
      if (n > 300) begin
        errors++;
        $display("FAIL timeout waiting req_ready inst%0d", inst);
        break;
      end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    vld[inst] = 1'b0;
    wr_en = 1'b0;
  endtask

  initial begin
    int c0;
    #12;
    chk("reset ready", 32'(rdy), 32'h0);
    chk("reset busy", 32'(bsy), 32'h0);
    chk("reset rsp_a", 32'(rsp[0]), 32'h0);
    chk("reset rsp_b", 32'(rsp[1]), 32'h0);
    chk("reset cnt_a", 32'(cnt_a), 32'h0);
    chk("reset cnt_b", cnt_b, 32'h0);
    @(posedge clk); #1;
    rst_n = 1'b1;

    wr(16'd5, 16'hBEEF);
    wr(16'd7, 16'h1234);
    wr(16'd8, 16'h5678);
    wr(16'd9, 16'h0001);
    wr(16'd3, 16'h0A0B);

    // Latency 2 basic read
    rd(0, 16'd5, 16'hBEEF);
    chk("cnt_a after 1 read", 32'(cnt_a), 32'd1);

    // Latency 0 back-to-back
    rd(1, 16'd7, 16'h1234);
    c0 = last_rdy_cyc;
    rd(1, 16'd8, 16'h5678);
    chk("lat0 ready period", 32'(last_rdy_cyc - c0), 32'd2);
    chk("cnt_b", cnt_b, 32'd2);

    // Latency 3 abort: valid dropped after one cycle
    @(posedge clk); #1;
    req_addr = 16'd5; vld[2] = 1'b1;
    @(posedge clk); #1;
    vld[2] = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    chk("abort busy", 32'(bsy[2]), 32'h0);
    chk("abort cnt_c", cnt_c, 32'd0);
    rd(2, 16'd5, 16'hBEEF);
    chk("cnt_c after read", cnt_c, 32'd1);

    // Read-first collision then re-read
    rd(0, 16'd9, 16'h0001, 1'b1, 16'h00FF);
    rd(0, 16'd9, 16'h00FF);

    // Upper address bits alias
    rd(1, 16'h0403, 16'h0A0B);

    // Reset while in S_WAIT
    @(posedge clk); #1;
    req_addr = 16'd5; vld[2] = 1'b1;
    @(posedge clk); #1;
    chk("wait busy", 32'(bsy[2]), 32'h1);
    rst_n = 1'b0;
    #1;
    chk("rst ready", 32'(rdy[2]), 32'h0);
    chk("rst busy", 32'(bsy[2]), 32'h0);
    chk("rst cnt_c", cnt_c, 32'd0);
    chk("rst cnt_a", 32'(cnt_a), 32'd0);
    vld[2] = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (8) @(posedge clk);
    #1;
    chk("post-rst cnt_c", cnt_c, 32'd0);
    rd(2, 16'd5, 16'hBEEF);

    // 4-bit counter wrap: 17 reads -> 1
    for (int k = 0; k < 17; k++) rd(0, 16'h0403, 16'h0A0B);
    chk("cnt_a wrap", 32'(cnt_a), 32'd1);

    repeat (4) @(posedge clk);
    #1;
    chk("scoreboard drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global timeout");
    $fatal(1, "timeout");
  end

endmodule
